// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, retries on timeout, then releases sys_reset.
// Optional build macro PLLSEQ_AUTO_RELOCK_EN: a lock loss in RUN re-pulses the PLL instead of re-qualifying.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int MAX_RETRIES      = 3,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          refclk,
    input  logic          rst_n,
    input  logic          locked,
    input  logic          restart,
    output logic          pll_rst,
    output logic          sys_reset,
    output logic          ready,
    output logic          fault,
    output logic [RW-1:0] retry_cnt
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
    localparam int CNT_MAX = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
    // The WAIT_LOCK cycle that first sees lock_s counts as the first stable cycle,
    // so STABLE itself only needs LOCK_STABLE_CYC-1 more.
    localparam logic [CW-1:0] STB_LAST = CW'((LOCK_STABLE_CYC >= 2) ? LOCK_STABLE_CYC - 2 : 0);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [RW-1:0] retry_nxt;
    logic [1:0]    lock_sync;
    logic          lock_s;

    assign lock_s = lock_sync[1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        retry_nxt = retry_cnt;
        if (restart) begin
            state_nxt = S_RESET;
            retry_nxt = '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == RST_LAST)
                        state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = (LOCK_STABLE_CYC <= 1) ? S_RUN : S_STABLE;
                    end else if (cnt == TMO_LAST) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state_nxt = S_FAULT;
                        end else begin
                            state_nxt = S_RESET;
                            retry_nxt = retry_cnt + 1'b1;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s)
                        state_nxt = S_WAIT_LOCK;
                    else if (cnt == STB_LAST)
                        state_nxt = S_RUN;
                end
                S_RUN: begin
                    cnt_nxt = cnt;
                    if (!lock_s) begin
`ifdef PLLSEQ_AUTO_RELOCK_EN
                        state_nxt = S_RESET;
`else
                        state_nxt = S_STABLE;
`endif
                    end
                end
                S_FAULT: cnt_nxt = cnt;
                default: state_nxt = S_RESET;
            endcase
        end
        if (restart || (state_nxt != state))
            cnt_nxt = '0;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= 2'b00;
            state     <= S_RESET;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            lock_sync <= {lock_sync[0], locked};
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_rst   <= (state_nxt == S_RESET) || (state_nxt == S_FAULT);
            sys_reset <= (state_nxt != S_RUN);
            ready     <= (state_nxt == S_RUN);
            fault     <= (state_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed timing checks plus random lock/restart/reset traffic
// compared every cycle against a phase-level reference model.
module tb_pll_reset_sequencer;

    localparam int RP  = 4;
    localparam int LS  = 8;
    localparam int TO  = 20;
    localparam int MR  = 2;
    localparam int SEL_PLL = 0, SEL_READY = 1, SEL_FAULT = 2;
    localparam int P_PULSE = 0, P_SEEK = 1, P_RUN = 2, P_FAULT = 3;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, sys_reset, ready, fault;
    logic [1:0] retry_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYC   (RP),
        .LOCK_STABLE_CYC (LS),
        .LOCK_TIMEOUT_CYC(TO),
        .MAX_RETRIES     (MR)
    ) dut (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .locked   (locked),
        .restart  (restart),
        .pll_rst  (pll_rst),
        .sys_reset(sys_reset),
        .ready    (ready),
        .fault    (fault),
        .retry_cnt(retry_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: PULSE -> SEEK (hunting + qualifying as one phase) -> RUN, or FAULT.
    int m_phase, m_pulse_t, m_seek_t, m_streak, m_retry;
    bit m_l1, m_l2;

    task automatic model_reset();
        m_phase = P_PULSE; m_pulse_t = 0; m_seek_t = 0; m_streak = 0; m_retry = 0;
        m_l1 = 0; m_l2 = 0;
    endtask

    task automatic model_edge(input bit lk, input bit rs);
        bit ls;
        ls = m_l2; m_l2 = m_l1; m_l1 = lk;
        if (rs) begin
            m_phase = P_PULSE; m_pulse_t = 0; m_retry = 0;
        end else begin
            case (m_phase)
                P_PULSE: begin
                    m_pulse_t++;
                    if (m_pulse_t == RP) begin
                        m_phase = P_SEEK; m_seek_t = 0; m_streak = 0;
                    end
                end
                P_SEEK: begin
                    if (ls) begin
                        m_streak++;
                        if (m_streak >= LS) m_phase = P_RUN;
                    end else if (m_streak > 0) begin
                        m_streak = 0; m_seek_t = 0;
                    end else begin
                        m_seek_t++;
                        if (m_seek_t == TO) begin
                            if (m_retry < MR) begin
                                m_retry++; m_phase = P_PULSE; m_pulse_t = 0;
                            end else begin
                                m_phase = P_FAULT;
                            end
                        end
                    end
                end
                P_RUN: begin
                    if (!ls) begin
`ifdef PLLSEQ_AUTO_RELOCK_EN
                        m_phase = P_PULSE; m_pulse_t = 0;
`else
                        m_phase = P_SEEK; m_streak = 1; m_seek_t = 0;
`endif
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [5:0] mdl_vec();
        logic [1:0] r;
        r = 2'(m_retry);
        return {(m_phase == P_PULSE) || (m_phase == P_FAULT), m_phase != P_RUN,
                m_phase == P_RUN, m_phase == P_FAULT, r};
    endfunction

    function automatic logic [5:0] dut_vec();
        return {pll_rst, sys_reset, ready, fault, retry_cnt};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            SEL_PLL:   return pll_rst;
            SEL_READY: return ready;
            SEL_FAULT: return fault;
            default:   return sys_reset;
        endcase
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic lk, input logic rs);
        locked = lk; restart = rs;
        @(posedge refclk);
        model_edge(lk, rs);
        #1;
        chk("cycle_vec", int'(dut_vec()), int'(mdl_vec()));
        @(negedge refclk);
    endtask

    task automatic run_until(input int sel, input logic val, input logic lk, input int budget,
                             output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step(lk, 1'b0);
            if (sig(sel) == val) begin
                n = i;
                break;
            end
        end
    endtask

    // Asynchronous reset between clock edges; outputs must change without a refclk edge.
    task automatic do_reset(input string tag);
        restart = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk(tag, int'(dut_vec()), 6'b110000);
        model_reset();
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int pll_hi;
        int hold;
        int c;
        logic lk;

        model_reset();
        repeat (2) @(negedge refclk);
        chk("reset_vec", int'(dut_vec()), 6'b110000);
        rst_n = 1'b1;

        // 1: nominal bring-up
        run_until(SEL_PLL, 1'b0, 1'b0, 50, n);
        chk("t1_pulse_len", n, RP);
        repeat (3) step(1'b0, 1'b0);
        run_until(SEL_READY, 1'b1, 1'b1, 50, n);
        chk("t1_ready_lat", n, 2 + LS);
        chk("t1_sys_reset", sys_reset, 0);

        // 2: one-cycle lock glitch while qualifying
        do_reset("t2_async_rst");
        run_until(SEL_PLL, 1'b0, 1'b0, 50, n);
        chk("t2_pulse_len", n, RP);
        repeat (7) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("t2_not_ready", ready, 0);
        run_until(SEL_READY, 1'b1, 1'b1, 50, n);
        chk("t2_ready_lat", n, 2 + LS);

        // 5: lock loss in RUN
        run_until(SEL_READY, 1'b0, 1'b0, 20, n);
        chk("t5_drop_lat", n, 3);
        chk("t5_sys_reset", sys_reset, 1);
`ifdef PLLSEQ_AUTO_RELOCK_EN
        chk("t5_pll_rst", pll_rst, 1);
        run_until(SEL_PLL, 1'b0, 1'b0, 50, n);
        chk("t5_repulse_len", n, RP);
`else
        chk("t5_pll_rst", pll_rst, 0);
        pll_hi = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            pll_hi += int'(pll_rst);
        end
        chk("t5_no_repulse", pll_hi, 0);
`endif

        // 3: no lock at all -> retries then FAULT
        do_reset("t3_async_rst");
        run_until(SEL_PLL, 1'b0, 1'b0, 50, n);
        chk("t3_pulse0", n, RP);
        for (int a = 1; a <= MR; a++) begin
            run_until(SEL_PLL, 1'b1, 1'b0, 50, n);
            chk("t3_gap", n, TO);
            chk("t3_retry", retry_cnt, a);
            run_until(SEL_PLL, 1'b0, 1'b0, 50, n);
            chk("t3_pulse", n, RP);
        end
        run_until(SEL_FAULT, 1'b1, 1'b0, 50, n);
        chk("t3_fault_lat", n, TO);
        chk("t3_fault_pll", pll_rst, 1);
        repeat (5) step(1'b0, 1'b0);
        chk("t3_fault_hold", fault, 1);

        // 4: restart out of FAULT
        step(1'b0, 1'b1);
        chk("t4_fault_clr", fault, 0);
        chk("t4_retry_clr", retry_cnt, 0);
        chk("t4_pll_rst", pll_rst, 1);
        run_until(SEL_PLL, 1'b0, 1'b0, 50, n);
        chk("t4_pulse_len", n, RP);

        // 6: async reset while qualifying lock
        repeat (5) step(1'b1, 1'b0);
        chk("t6_in_stable", int'(dut_vec()), 6'b010000);
        do_reset("t6_async_rst");

        // Random traffic: lock held for random spans, rare restarts and async resets
        c = 0;
        while (c < 4000) begin
            lk = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       hold = $urandom_range(1, 3);
                3:       hold = $urandom_range(41, 100);
                default: hold = $urandom_range(4, 40);
            endcase
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 799) == 0)
                    do_reset("rnd_async_rst");
                step(lk, $urandom_range(0, 149) == 0);
                c++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
